// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg
// Shared definitions for the CPU clock-control block: the controller
// state encoding and the default timing constants used as parameter
// defaults by cpu_clk_ctrl and btn_debounce.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        S_STOP = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } clk_state_t;

    // clk_in cycles per half-period of clk_cpu (legal range >= 2)
    localparam int DEF_DIV_HALF   = 50;

    // Consecutive stable clk_in cycles before the debounced level moves
    localparam int DEF_DEB_CYCLES = 1000000;

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// btn_debounce
// Synchronises an asynchronous, bouncy push button into the clk_in
// domain, debounces it and produces a one-cycle pulse on each debounced
// press.
//
// Ports:
//   clk_in     - board clock
//   reset      - asynchronous, active-high reset
//   btn        - raw button input (asynchronous)
//   level      - debounced button level
//   rise_pulse - one clk_in cycle pulse on the debounced 0->1 edge
module btn_debounce
    import cpu_clk_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk_in,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_stableCnt;

    logic          w_differ;
    logic          w_settle;

    // The level only moves once the synced input has disagreed with it for
    // DEB_CYCLES consecutive cycles; any agreeing cycle restarts the count.
    assign w_differ = (r_sync2 != r_level);
    assign w_settle = w_differ && (r_stableCnt == CW'(DEB_CYCLES - 1));

    // Two-flop synchroniser, stability counter and edge detector
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_level     <= 1'b0;
            r_rise      <= 1'b0;
            r_stableCnt <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            if (!w_differ || w_settle) begin
                r_stableCnt <= '0;
            end else begin
                r_stableCnt <= r_stableCnt + 1'b1;
            end
            if (w_settle) begin
                r_level <= r_sync2;
            end
            // Registered alongside the level so the pulse coincides with
            // the first cycle of the new high level.
            r_rise <= w_settle && r_sync2;
        end
    end

    assign level      = r_level;
    assign rise_pulse = r_rise;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl
// Generates the single-cycle CPU clock from the board clock with
// run/stop control, debounced single-step and a PC breakpoint.
//
// Ports:
//   clk_in    - board clock, the only clock in the block
//   reset     - asynchronous, active-high reset
//   run_mode  - 1 = free run, 0 = stop/step (asynchronous switch)
//   step_btn  - single-step push button (asynchronous, bouncy)
//   bp_en     - breakpoint enable
//   bp_addr   - breakpoint PC
//   pc_in     - current CPU PC
//   clk_cpu   - registered CPU clock
//   cpu_tick  - one-cycle pulse coincident with each clk_cpu rise
//   halted    - 1 while stopped
//   bp_hit    - sticky breakpoint-hit flag
//   cycle_cnt - clk_cpu rising edges since reset (wrapping)
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV_HALF   = DEF_DIV_HALF,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             run_mode,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc_in,
    output logic             clk_cpu,
    output logic             cpu_tick,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int DIV_W = $clog2(DIV_HALF);

    clk_state_t       r_state;
    logic             r_halted;
    logic             r_runSync1;
    logic             r_runSync2;
    logic [DIV_W-1:0] r_divCnt;
    logic             r_clkCpu;
    logic             r_tick;
    logic             r_bpHit;
    logic [CNT_W-1:0] r_cycleCnt;

    clk_state_t       w_stateNext;
    logic             w_bpHitNext;
    logic             w_stepLevel;
    logic             w_stepRise;
    logic             w_stepPulse;
    logic             w_toggle;
    logic             w_rise;
    logic             w_fall;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_stepDeb (
        .clk_in     (clk_in),
        .reset      (reset),
        .btn        (step_btn),
        .level      (w_stepLevel),
        .rise_pulse (w_stepRise)
    );

    // The edge is qualified with the settled level; both move together.
    assign w_stepPulse = w_stepRise && w_stepLevel;

    assign w_toggle = (r_state != S_STOP) && (r_divCnt == DIV_W'(DIV_HALF - 1));
    assign w_rise   = w_toggle && !r_clkCpu;
    assign w_fall   = w_toggle && r_clkCpu;

    // Next-state logic: run/stop decisions are only taken at the end of a
    // full clk_cpu period so no period is ever truncated.
    always_comb begin
        w_stateNext = r_state;
        w_bpHitNext = r_bpHit;
        case (r_state)
            S_STOP: begin
                if (!r_runSync2) begin
                    w_bpHitNext = 1'b0;
                end
                if (w_stepPulse && !r_runSync2) begin
                    w_stateNext = S_STEP;
                end else if (r_runSync2 && !r_bpHit) begin
                    w_stateNext = S_RUN;
                end
            end
            S_RUN: begin
                if (w_fall) begin
                    if (!r_runSync2) begin
                        w_stateNext = S_STOP;
                    end else if (bp_en && (pc_in == bp_addr)) begin
                        w_stateNext = S_STOP;
                        w_bpHitNext = 1'b1;
                    end
                end
            end
            S_STEP: begin
                if (w_fall) begin
                    w_stateNext = S_STOP;
                end
            end
            default: begin
                w_stateNext = S_STOP;
            end
        endcase
    end

    // State, divider, clock output and counters
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state    <= S_STOP;
            r_halted   <= 1'b1;
            r_runSync1 <= 1'b0;
            r_runSync2 <= 1'b0;
            r_divCnt   <= '0;
            r_clkCpu   <= 1'b0;
            r_tick     <= 1'b0;
            r_bpHit    <= 1'b0;
            r_cycleCnt <= '0;
        end else begin
            r_runSync1 <= run_mode;
            r_runSync2 <= r_runSync1;
            r_state    <= w_stateNext;
            r_halted   <= (w_stateNext == S_STOP);
            r_bpHit    <= w_bpHitNext;
            if (r_state == S_STOP) begin
                r_divCnt <= '0;
            end else if (w_toggle) begin
                r_divCnt <= '0;
                r_clkCpu <= ~r_clkCpu;
            end else begin
                r_divCnt <= r_divCnt + 1'b1;
            end
            r_tick <= w_rise;
            if (w_rise) begin
                r_cycleCnt <= r_cycleCnt + 1'b1;
            end
        end
    end

    assign clk_cpu   = r_clkCpu;
    assign cpu_tick  = r_tick;
    assign halted    = r_halted;
    assign bp_hit    = r_bpHit;
    assign cycle_cnt = r_cycleCnt;

endmodule
